// File: rtl/pet_memctl.sv
// PET memory-map controller: CPU address decode, 8096-style expansion banking,
// and a shared physical RAM port arbitrated between the CPU and a DMA requester.
module pet_memctl #(
    parameter int unsigned RAM_DEPTH = 15,
    parameter bit          EXP_EN    = 1'b1,
    parameter logic [15:0] CTRL_ADDR = 16'hFFF0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce_1m,
    input  logic [15:0] addr,
    input  logic [7:0]  data_in,
    input  logic        we,
    output logic [7:0]  data_out,
    input  logic [7:0]  ram_q,
    input  logic [7:0]  vram_q,
    input  logic [7:0]  io_q,
    input  logic [7:0]  rom_q,
    output logic [16:0] mem_addr,
    output logic [7:0]  mem_din,
    output logic        mem_we,
    output logic        vram_we,
    output logic        io_we,
    input  logic        dma_req,
    input  logic [16:0] dma_addr,
    input  logic [7:0]  dma_din,
    input  logic        dma_we,
    output logic        dma_ack,
    output logic [7:0]  dma_dout
);

    localparam int unsigned RAM_SIZE = 32'd1 << RAM_DEPTH;
    localparam logic [16:0] EXP_BASE = 17'h08000;
    localparam logic [7:0]  OPEN_BUS = 8'h55;

    typedef enum logic [2:0] {SEL_NONE, SEL_RAM, SEL_VRAM, SEL_IO, SEL_ROM} sel_t;
    typedef enum logic [1:0] {IDLE, WAIT, ACC, ACK} dma_state_t;

    logic [7:0]  ctrl;
    sel_t        sel;
    sel_t        sel_q;
    dma_state_t  state;
    logic [16:0] cpu_addr;
    logic [1:0]  bank;
    logic        wp;
    logic        base_ok;
    logic        in_io;
    logic        ctrl_hit;
    logic        cpu_wr;
    logic        dma_port;

    // Address decode: region, physical RAM address and write-protect for the CPU access
    always_comb begin
        sel      = SEL_NONE;
        cpu_addr = {2'b00, addr[14:0]};
        wp       = 1'b0;
        base_ok  = 32'(addr[14:0]) < RAM_SIZE;
        in_io    = (addr[15:11] == 5'b11101);
        bank     = addr[14] ? {1'b1, ctrl[3]} : {1'b0, ctrl[2]};
        if (!addr[15]) begin
            if (base_ok) sel = SEL_RAM;
        end else if (ctrl[7]) begin
            if (ctrl[5] && addr[14:12] == 3'b000) begin
                sel = SEL_VRAM;
            end else if (ctrl[6] && in_io) begin
                sel = SEL_IO;
            end else begin
                sel      = SEL_RAM;
                cpu_addr = EXP_BASE + {1'b0, bank, addr[13:0]};
                wp       = addr[14] ? ctrl[1] : ctrl[0];
            end
        end else begin
            if (addr[14:11] == 4'b0000)     sel = SEL_VRAM;
            else if (addr[14:12] == 3'b000) sel = SEL_NONE;
            else if (in_io)                 sel = SEL_IO;
            else                            sel = SEL_ROM;
        end
    end

    // Physical port: DMA only gets it in WAIT on a cycle the CPU is not using
    assign ctrl_hit = (addr == CTRL_ADDR);
    assign cpu_wr   = ce_1m & we & ~ctrl_hit;
    assign dma_port = (state == WAIT) & ~ce_1m;
    assign mem_addr = dma_port ? dma_addr : cpu_addr;
    assign mem_din  = dma_port ? dma_din : data_in;
    assign mem_we   = dma_port ? dma_we : (cpu_wr & (sel == SEL_RAM) & ~wp);
    assign vram_we  = cpu_wr & (sel == SEL_VRAM);
    assign io_we    = cpu_wr & (sel == SEL_IO);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl <= 8'h00;
        end else if (EXP_EN && ce_1m && we && ctrl_hit) begin
            ctrl <= data_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q <= SEL_NONE;
        end else if (ce_1m) begin
            sel_q <= sel;
        end
    end

    always_comb begin
        data_out = OPEN_BUS;
        case (sel_q)
            SEL_RAM:  data_out = ram_q;
            SEL_VRAM: data_out = vram_q;
            SEL_IO:   data_out = io_q;
            SEL_ROM:  data_out = rom_q;
            default:  data_out = OPEN_BUS;
        endcase
    end

    // DMA arbiter; ram_q in ACC holds the data addressed during the WAIT access
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            dma_ack  <= 1'b0;
            dma_dout <= 8'h00;
        end else begin
            dma_ack <= 1'b0;
            case (state)
                IDLE: if (dma_req) state <= WAIT;
                WAIT: if (!ce_1m) state <= ACC;
                ACC: begin
                    dma_dout <= ram_q;
                    dma_ack  <= 1'b1;
                    state    <= ACK;
                end
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pet_memctl.sv
// Directed bench for pet_memctl: decode, banking, peek-through, write protect,
// DMA arbitration and a reduced-RAM instance.
module tb_pet_memctl;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce_1m;
    logic [15:0] addr;
    logic [7:0]  data_in;
    logic        we;
    logic [7:0]  data_out, data_out14;
    logic [7:0]  ram_q, vram_q, io_q, rom_q;
    logic [16:0] mem_addr, mem_addr14;
    logic [7:0]  mem_din, mem_din14;
    logic        mem_we, mem_we14;
    logic        vram_we, vram_we14;
    logic        io_we, io_we14;
    logic        dma_req;
    logic [16:0] dma_addr;
    logic [7:0]  dma_din;
    logic        dma_we;
    logic        dma_ack, dma_ack14;
    logic [7:0]  dma_dout, dma_dout14;

    int n_cmp = 0;
    int n_bad = 0;

    logic [16:0] c_addr;
    logic        c_mwe, c_vwe, c_iwe, c_mwe14;
    logic [7:0]  c_rd, c_rd14;

    logic [7:0] ram [0:131071];

    always #5 clk = ~clk;

    pet_memctl dut (
        .clk(clk), .reset(reset), .ce_1m(ce_1m), .addr(addr), .data_in(data_in), .we(we),
        .data_out(data_out), .ram_q(ram_q), .vram_q(vram_q), .io_q(io_q), .rom_q(rom_q),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .vram_we(vram_we),
        .io_we(io_we), .dma_req(dma_req), .dma_addr(dma_addr), .dma_din(dma_din),
        .dma_we(dma_we), .dma_ack(dma_ack), .dma_dout(dma_dout)
    );

    pet_memctl #(.RAM_DEPTH(14)) dut14 (
        .clk(clk), .reset(reset), .ce_1m(ce_1m), .addr(addr), .data_in(data_in), .we(we),
        .data_out(data_out14), .ram_q(ram_q), .vram_q(vram_q), .io_q(io_q), .rom_q(rom_q),
        .mem_addr(mem_addr14), .mem_din(mem_din14), .mem_we(mem_we14), .vram_we(vram_we14),
        .io_we(io_we14), .dma_req(dma_req), .dma_addr(dma_addr), .dma_din(dma_din),
        .dma_we(dma_we), .dma_ack(dma_ack14), .dma_dout(dma_dout14)
    );

    // Source models, each with one clock of read latency
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_din;
        ram_q  <= ram[mem_addr];
        vram_q <= 8'hB6;
        io_q   <= 8'hC3;
        rom_q  <= 8'hA5;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One CPU cycle: strobes captured mid-cycle, read data captured at ce+1
    task automatic cpu_cycle(input logic [15:0] a, input logic [7:0] d, input logic w);
        @(posedge clk); #1;
        addr = a; data_in = d; we = w; ce_1m = 1'b1;
        #2;
        c_addr = mem_addr; c_mwe = mem_we; c_vwe = vram_we; c_iwe = io_we; c_mwe14 = mem_we14;
        @(posedge clk); #1;
        ce_1m = 1'b0; we = 1'b0;
        c_rd = data_out; c_rd14 = data_out14;
    endtask

    initial begin
        int lat;
        bit got_ack;
        reset = 1'b1; ce_1m = 1'b0; addr = 16'hFFF0; data_in = 8'h00; we = 1'b0;
        dma_req = 1'b0; dma_addr = 17'h0; dma_din = 8'h00; dma_we = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data_out", 32'(data_out), 32'h55);
        chk("rst_dma_ack", 32'(dma_ack), 32'h0);
        chk("rst_dma_dout", 32'(dma_dout), 32'h00);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        reset = 1'b0;

        cpu_cycle(16'hC000, 8'h00, 1'b0);
        chk("rom_read", 32'(c_rd), 32'hA5);

        cpu_cycle(16'hFFF0, 8'h80, 1'b1);
        chk("ctrl_wr_no_mem", 32'(c_mwe), 32'h0);
        cpu_cycle(16'hC123, 8'h3C, 1'b1);
        chk("bank2_addr", 32'(c_addr), 32'h10123);
        chk("bank2_we", 32'(c_mwe), 32'h1);
        cpu_cycle(16'hC123, 8'h00, 1'b0);
        chk("bank2_read", 32'(c_rd), 32'h3C);

        cpu_cycle(16'hFFF0, 8'h82, 1'b1);
        cpu_cycle(16'hD000, 8'h44, 1'b1);
        chk("wp_high_we", 32'(c_mwe), 32'h0);
        cpu_cycle(16'h9000, 8'h45, 1'b1);
        chk("bank0_addr", 32'(c_addr), 32'h09000);
        chk("bank0_we", 32'(c_mwe), 32'h1);

        cpu_cycle(16'hFFF0, 8'hE0, 1'b1);
        cpu_cycle(16'hE810, 8'h00, 1'b0);
        chk("io_peek_read", 32'(c_rd), 32'hC3);
        cpu_cycle(16'h8005, 8'h12, 1'b1);
        chk("scr_peek_vwe", 32'(c_vwe), 32'h1);
        chk("scr_peek_mwe", 32'(c_mwe), 32'h0);
        cpu_cycle(16'h0123, 8'h11, 1'b1);
        chk("base_addr", 32'(c_addr), 32'h00123);

        // DMA write colliding with two back-to-back CPU cycles
        @(posedge clk); #1;
        addr = 16'h0123; we = 1'b0; ce_1m = 1'b1;
        dma_req = 1'b1; dma_addr = 17'h00100; dma_din = 8'h77; dma_we = 1'b1;
        @(posedge clk); #3;
        chk("col_cpu_addr", 32'(mem_addr), 32'h00123);
        chk("col_cpu_we", 32'(mem_we), 32'h0);
        @(posedge clk); #1;
        ce_1m = 1'b0;
        #2;
        chk("dma_port_addr", 32'(mem_addr), 32'h00100);
        chk("dma_port_we", 32'(mem_we), 32'h1);
        @(posedge clk); #1;
        chk("col_ack_early", 32'(dma_ack), 32'h0);
        @(posedge clk); #1;
        chk("col_ack_4clk", 32'(dma_ack), 32'h1);
        dma_req = 1'b0; dma_we = 1'b0;
        @(posedge clk); #1;
        chk("ack_one_clk", 32'(dma_ack), 32'h0);

        // DMA read without collision
        @(posedge clk); #1;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 17'h00100;
        lat = 0; got_ack = 1'b0;
        for (int i = 1; i <= 10 && !got_ack; i++) begin
            @(posedge clk); #1;
            if (dma_ack) begin
                got_ack = 1'b1;
                lat = i;
            end
        end
        dma_req = 1'b0;
        chk("dma_rd_latency", 32'(lat), 32'd3);
        chk("dma_rd_data", 32'(dma_dout), 32'h77);
        repeat (3) @(posedge clk);
        #1;
        chk("dma_dout_held", 32'(dma_dout), 32'h77);
        cpu_cycle(16'h0100, 8'h00, 1'b0);
        chk("cpu_sees_dma", 32'(c_rd), 32'h77);

        // 16 KB base RAM instance
        cpu_cycle(16'h4000, 8'h00, 1'b0);
        chk("d14_read_hole", 32'(c_rd14), 32'h55);
        cpu_cycle(16'h4000, 8'h99, 1'b1);
        chk("d14_write_hole", 32'(c_mwe14), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
